alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter that time-shares one combinational ALU (`alu`, 4-bit `mod` opcode) between two requesters, e.g. the EX stage and a multi-cycle helper unit. Each port issues an operation with a valid/ready handshake. The block computes the result through the shared ALU, registers it, and returns it to the issuing port with its own valid/ready handshake. One result slot gives full throughput when responses are consumed immediately, and back-pressure otherwise.

## Interface
Parameters:
- `NPORT`, 2: number of requesters; fixed at 2, not overridable.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  bit i: port i presents an operation.
- `req_ready`  out  2  bit i: port i's operation is accepted this cycle.
- `req_d1_0`, `req_d1_1`  in  32 each  ALU operand `d1` for port 0 / port 1.
- `req_d2_0`, `req_d2_1`  in  32 each  ALU operand `d2` for port 0 / port 1.
- `req_mod_0`, `req_mod_1`  in  4 each  ALU opcode for port 0 / port 1.
- `rsp_valid`  out  2  bit i: the result slot holds port i's result.
- `rsp_ready`  in  2  bit i: port i consumes its result.
- `rsp_data`  out  32  registered result; meaningful only while some `rsp_valid` bit is set.
- `busy`  out  1  result slot occupied.

## Operation
- The ALU is instantiated internally. Opcode decode is unchanged from `alu`; unknown opcodes yield 0.
- Slot states:
  - EMPTY: no result held.
  - FULL: result held; `owner` records the issuing port.
- Issue is permitted when `slot_free` = EMPTY, or FULL with `rsp_ready[owner]`=1 (same-cycle drain and refill).
- Grant rule (round-robin):
  - Only one valid port: that port wins.
  - Both ports valid: the port not granted last wins.
  - `last` pointer updates only on an accepted issue.
- `req_ready[i]` = `slot_free` & grant[i]. At most one bit is set. `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
- Accepted issue, i.e. `req_valid[i]` & `req_ready[i]`:
  - Register ALU(d1_i, d2_i, mod_i) into `rsp_data`.
  - Set `owner` = i.
  - State becomes FULL.
- `rsp_valid[i]` = FULL & (`owner`==i).
- Drain without issue: FULL → EMPTY. `rsp_data` holds its last value.
- Once asserted, a result is held stable until consumed: `rsp_data` and `owner` do not change while FULL without a handshake.
- `rsp_ready` on a port not owning the slot is ignored.
- Reset values:
  - `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - State EMPTY, `last` = port 1, so port 0 wins the first contention.
  - `req_ready`=0 while `reset` is low.
- Reset asserted mid-operation: the held result is discarded and no response is issued for it.

## Timing
- Latency: issue accepted at edge N → `rsp_valid`/`rsp_data` visible after edge N, i.e. cycle N+1. Exactly 1 cycle, independent of opcode.
- Throughput: 1 op/cycle while the owner holds `rsp_ready`=1.
- Back-pressure: with the owner's `rsp_ready`=0, both `req_ready` bits stay 0 until the cycle the owner drains.
- Simultaneous drain and issue by the same port in one cycle is legal; the slot stays FULL with the new result.
- Simultaneous drain by port 0 and issue by port 1 is legal; `owner` switches to 1 on the same edge.
- `busy` = FULL, registered.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; port 0 always wins contention.
  - `last` pointer is not implemented.
  - Port 1 can starve.
- Not defined: round-robin as specified above (default).

## Test plan
- Single port: port 0 issues d1=5, d2=3, mod=`alu_sub`, `rsp_ready[0]`=1 → next cycle `rsp_valid`=2'b01, `rsp_data`=2; `busy` returns to 0 the cycle after.
- Contention, round-robin: both ports valid every cycle, both `rsp_ready`=1 → grants alternate 0,1,0,1. Issue port0 add 1+1 and port1 or 0xF0|0x0F → results 2 then 0xFF, each tagged to the correct `rsp_valid` bit.
- Back-pressure: port 1 result pending with `rsp_ready[1]`=0 for 4 cycles and port 0 valid → `req_ready`=0 for those cycles and `rsp_data` stable. On the drain cycle, port 0 is accepted in the same cycle.
- Shift/compare passthrough: mod=`alu_sra`, d1=4, d2=0x80000000 → 0xF8000000. mod=`alu_slt_signed`, d1=-1, d2=1 → 1. Unknown mod 4'b1111 → 0.
- Async reset mid-hold: assert `reset` low between clock edges while FULL → `rsp_valid`=0 and `busy`=0 immediately. After release, first contention grants port 0.
- `ALU_ARB_FIXED_PRIO_EN` build: both ports valid continuously → port 0 granted every cycle, port 1 never.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter sharing one combinational ALU through a single result slot.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention, no last pointer).

module alu (
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [3:0]  mod,
    output logic [31:0] out
);
    localparam logic [3:0] ALU_ADD          = 4'd0;
    localparam logic [3:0] ALU_SUB          = 4'd1;
    localparam logic [3:0] ALU_AND          = 4'd2;
    localparam logic [3:0] ALU_OR           = 4'd3;
    localparam logic [3:0] ALU_XOR          = 4'd4;
    localparam logic [3:0] ALU_SLL          = 4'd5;
    localparam logic [3:0] ALU_SRL          = 4'd6;
    localparam logic [3:0] ALU_SRA          = 4'd7;
    localparam logic [3:0] ALU_SLT_SIGNED   = 4'd8;
    localparam logic [3:0] ALU_SLT_UNSIGNED = 4'd9;

    // Shifts move d2 by the amount in d1[4:0].
    always_comb begin
        out = '0;
        case (mod)
            ALU_ADD:          out = d1 + d2;
            ALU_SUB:          out = d1 - d2;
            ALU_AND:          out = d1 & d2;
            ALU_OR:           out = d1 | d2;
            ALU_XOR:          out = d1 ^ d2;
            ALU_SLL:          out = d2 << d1[4:0];
            ALU_SRL:          out = d2 >> d1[4:0];
            ALU_SRA:          out = $unsigned($signed(d2) >>> d1[4:0]);
            ALU_SLT_SIGNED:   out = {31'd0, $signed(d1) < $signed(d2)};
            ALU_SLT_UNSIGNED: out = {31'd0, d1 < d2};
            default:          out = '0;
        endcase
    end
endmodule

module alu_share_arb #(
    localparam int NPORT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] req_valid,
    output logic [NPORT-1:0] req_ready,
    input  logic [31:0]      req_d1_0,
    input  logic [31:0]      req_d1_1,
    input  logic [31:0]      req_d2_0,
    input  logic [31:0]      req_d2_1,
    input  logic [3:0]       req_mod_0,
    input  logic [3:0]       req_mod_1,
    output logic [NPORT-1:0] rsp_valid,
    input  logic [NPORT-1:0] rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             busy
);
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [NPORT-1:0] grant;
    logic        slot_free;
    logic        issue;
    logic        sel;
    logic [31:0] alu_d1, alu_d2, alu_out;
    logic [3:0]  alu_mod;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        last_q;
`endif

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   grant = 2'b01;
`else
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
`endif
            default: grant = '0;
        endcase
    end

    // A full slot frees up in the same cycle its owner drains it.
    assign slot_free = (state_q == S_EMPTY) || rsp_ready[owner_q];
    assign req_ready = (reset && slot_free) ? grant : '0;
    assign issue     = |(req_valid & req_ready);
    assign sel       = req_ready[1];

    assign alu_d1  = sel ? req_d1_1  : req_d1_0;
    assign alu_d2  = sel ? req_d2_1  : req_d2_0;
    assign alu_mod = sel ? req_mod_1 : req_mod_0;

    alu u_alu (
        .d1  (alu_d1),
        .d2  (alu_d2),
        .mod (alu_mod),
        .out (alu_out)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rsp_data_d = rsp_data_q;
        if (issue) begin
            state_d    = S_FULL;
            owner_d    = sel;
            rsp_data_d = alu_out;
        end else if ((state_q == S_FULL) && rsp_ready[owner_q]) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            owner_q    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Starts at port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (issue) begin
            last_q <= sel;
        end
    end
`endif

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rsp_valid
        assign rsp_valid[gi] = (state_q == S_FULL) && (owner_q == 1'(gi));
    end

    assign rsp_data = rsp_data_q;
    assign busy     = (state_q == S_FULL);
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: expected results queued at issue, compared on response.
`timescale 1ns/1ps
module tb_alu_share_arb;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_BAD  = 4'd15;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_d1_0, req_d1_1, req_d2_0, req_d2_1, rsp_data;
    logic [3:0]  req_mod_0, req_mod_1;
    logic        busy;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_last;
    exp_t sb_q[$];
    exp_t e;

    logic [3:0]  op_tab  [10];
    logic [31:0] d1_tab  [10];
    logic [31:0] d2_tab  [10];
    logic [31:0] res_tab [10];

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_d1_0  (req_d1_0),
        .req_d1_1  (req_d1_1),
        .req_d2_0  (req_d2_0),
        .req_d2_1  (req_d2_1),
        .req_mod_0 (req_mod_0),
        .req_mod_1 (req_mod_1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic grant_both();
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return !exp_last;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        req_d1_0 = 0; req_d2_0 = 0; req_mod_0 = OP_ADD;
        req_d1_1 = 0; req_d2_1 = 0; req_mod_1 = OP_ADD;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        rst_n = 1'b1; req_valid = 2'b00; exp_last = 1'b1; sb_q.delete();
        tick();
    endtask

    task automatic test_contention();
        logic g;
        req_d1_0 = 32'd1;   req_d2_0 = 32'd1;   req_mod_0 = OP_ADD;
        req_d1_1 = 32'hF0;  req_d2_1 = 32'h0F;  req_mod_1 = OP_OR;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            g = grant_both();
            n_cmp++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contention_grant%0d got=%b want_port=%0d", i, req_ready, g); end
            e.port = g; e.data = g ? 32'hFF : 32'd2;
            sb_q.push_back(e);
            exp_last = g;
            tick();
            e = sb_q.pop_front();
            $display("contention txn %0d: port%0d rsp_valid=%b data=%h", i, e.port, rsp_valid, rsp_data);
            n_cmp++; if (rsp_valid !== (e.port ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contention_rsp_valid%0d got=%b want_port=%0d", i, rsp_valid, e.port); end
            n_cmp++; if (rsp_data !== e.data) begin n_err++; $display("FAIL contention_rsp_data%0d got=%h want=%h", i, rsp_data, e.data); end
        end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_err++; $display("FAIL contention_idle busy=%b rsp_valid=%b want 0/00", busy, rsp_valid); end
    endtask

    task automatic test_single();
        req_d1_0 = 32'd5; req_d2_0 = 32'd3; req_mod_0 = OP_SUB;
        req_valid = 2'b01; rsp_ready = 2'b01;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_req_ready got=%b want=01", req_ready); end
        e.port = 1'b0; e.data = 32'd2; sb_q.push_back(e); exp_last = 1'b0;
        tick();
        req_valid = 2'b00;
        e = sb_q.pop_front();
        $display("single txn: port0 rsp_valid=%b data=%h", rsp_valid, rsp_data);
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got=%b want=01", rsp_valid); end
        n_cmp++; if (rsp_data !== e.data) begin n_err++; $display("FAIL single_rsp_data got=%h want=%h", rsp_data, e.data); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_set got=%b want=1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clear got=%b want=0", busy); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_rsp_idle got=%b want=00", rsp_valid); end
    endtask

    task automatic test_ops();
        rsp_ready = 2'b01;
        for (int i = 0; i < 10; i++) begin
            req_d1_0 = d1_tab[i]; req_d2_0 = d2_tab[i]; req_mod_0 = op_tab[i];
            req_valid = 2'b01;
            #1;
            n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL ops_req_ready%0d got=%b want=01", i, req_ready); end
            e.port = 1'b0; e.data = res_tab[i]; sb_q.push_back(e); exp_last = 1'b0;
            tick();
            e = sb_q.pop_front();
            $display("ops txn %0d: mod=%0d rsp_valid=%b data=%h", i, op_tab[i], rsp_valid, rsp_data);
            n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL ops_rsp_valid%0d got=%b want=01", i, rsp_valid); end
            n_cmp++; if (rsp_data !== e.data) begin n_err++; $display("FAIL ops_rsp_data%0d got=%h want=%h", i, rsp_data, e.data); end
        end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ops_busy_clear got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        req_d1_1 = 32'd10; req_d2_1 = 32'd4; req_mod_1 = OP_SUB;
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_issue1 got=%b want=10", req_ready); end
        e.port = 1'b1; e.data = 32'd6; sb_q.push_back(e); exp_last = 1'b1;
        tick();
        req_d1_0 = 32'd7; req_d2_0 = 32'd8; req_mod_0 = OP_ADD;
        req_valid = 2'b01; rsp_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("bp hold %0d: req_ready=%b rsp_valid=%b data=%h", i, req_ready, rsp_valid, rsp_data);
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_req_ready%0d got=%b want=00", i, req_ready); end
            n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_rsp_valid%0d got=%b want=10", i, rsp_valid); end
            n_cmp++; if (rsp_data !== sb_q[0].data) begin n_err++; $display("FAIL bp_rsp_data%0d got=%h want=%h", i, rsp_data, sb_q[0].data); end
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_drain_issue got=%b want=01", req_ready); end
        e = sb_q.pop_front();
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== e.data) begin n_err++; $display("FAIL bp_drain_rsp got=%b/%h want=10/%h", rsp_valid, rsp_data, e.data); end
        e.port = 1'b0; e.data = 32'd15; sb_q.push_back(e); exp_last = 1'b0;
        tick();
        req_valid = 2'b00; rsp_ready = 2'b01;
        e = sb_q.pop_front();
        $display("bp txn: port0 rsp_valid=%b data=%h", rsp_valid, rsp_data);
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_owner_switch got=%b want=01", rsp_valid); end
        n_cmp++; if (rsp_data !== e.data) begin n_err++; $display("FAIL bp_new_data got=%h want=%h", rsp_data, e.data); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_clear got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        req_d1_1 = 32'h3; req_d2_1 = 32'h5; req_mod_1 = OP_XOR;
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL arst_issue got=%b want=10", req_ready); end
        e.port = 1'b1; e.data = 32'h6; sb_q.push_back(e); exp_last = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== sb_q[0].data) begin n_err++; $display("FAIL arst_full got=%b/%h want=10/%h", rsp_valid, rsp_data, sb_q[0].data); end
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        $display("arst txn: rsp_valid=%b busy=%b req_ready=%b", rsp_valid, busy, req_ready);
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL arst_rsp_valid got=%b want=00", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b want=0", busy); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL arst_req_ready got=%b want=00", req_ready); end
        sb_q.delete(); exp_last = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req_d1_0 = 32'd1; req_d2_0 = 32'd1; req_mod_0 = OP_ADD; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL arst_first_grant got=%b want=01", req_ready); end
        e.port = 1'b0; e.data = 32'd2; sb_q.push_back(e); exp_last = 1'b0;
        tick();
        req_valid = 2'b00;
        e = sb_q.pop_front();
        n_cmp++; if (rsp_valid !== 2'b01 || rsp_data !== e.data) begin n_err++; $display("FAIL arst_post_rsp got=%b/%h want=01/%h", rsp_valid, rsp_data, e.data); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy_clear got=%b want=0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        op_tab  = '{OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_BAD, OP_ADD};
        d1_tab  = '{32'd5, 32'hF0F01234, 32'hFFFF0000, 32'd4, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
        d2_tab  = '{32'd3, 32'h0FF0FFFF, 32'h0F0F0F0F, 32'd1, 32'h80000000, 32'h80000000, 32'd1, 32'd1, 32'd3, 32'd2};
        res_tab = '{32'd2, 32'h00F01234, 32'hF0F00F0F, 32'h10, 32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'd0, 32'd1};
        test_reset();
        test_contention();
        test_single();
        test_ops();
        test_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
